// File: rtl/counter_pkg.sv
// counter_pkg: shared constants and helpers for the counter block.
//   DefaultWidth - default count/limit width in bits
//   DefaultStep  - default increment per clock
//   count_period - cycles per count period for a given limit and step
package counter_pkg;

  localparam int unsigned DefaultWidth = 4;
  localparam int unsigned DefaultStep  = 1;

  // One cycle per step taken to reach max (the last step clamps to max),
  // plus the cycle that returns to zero.
  function automatic int unsigned count_period(input int unsigned max,
                                               input int unsigned step);
    if (step == 0) begin
      return 0;
    end
    return (max + step - 1) / step + 1;
  endfunction

endpackage

// File: rtl/counter_if.sv
// counter_if: bundles the control and status signals of one counter.
//   reset   - synchronous active-high reset request
//   max     - inclusive upper count limit
//   hit_top - count has reached the limit
//   value   - current count
// The master drives reset/max and observes the count; the slave is the
// counter side.
interface counter_if
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
);

  logic             reset;
  logic [WIDTH-1:0] max;
  logic             hit_top;
  logic [WIDTH-1:0] value;

  modport master (
    output reset,
    output max,
    input  hit_top,
    input  value
  );

  modport slave (
    input  reset,
    input  max,
    output hit_top,
    output value
  );

endinterface

// File: rtl/counter_next.sv
// counter_next: combinational next-count computation.
//   value - current count
//   max   - inclusive upper limit
//   next  - count to load on the next edge
// Wraps to 0 once the count reaches max, otherwise adds STEP and clamps to
// max so the limit value is never skipped.
module counter_next
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned STEP  = DefaultStep
) (
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] next
);

  localparam logic [WIDTH:0] StepExt = (WIDTH + 1)'(STEP);

  // One extra bit so value + STEP cannot wrap around before the clamp test.
  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, value} + StepExt;
    if (value >= max) begin
      next = '0;
    end else if (sum > {1'b0, max}) begin
      next = max;
    end else begin
      next = sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/counter.sv
// counter: wrapping up-counter with an inclusive programmable limit.
//   i_clk    - clock, all state changes on its rising edge
//   i_reset  - synchronous active-high reset, loads 0
//   i_max    - inclusive upper count limit
//   o_hitTop - high while the count is at or above i_max (combinational)
//   o_value  - current count, straight from the register
// Optional: define COUNTER_ASSERT_EN to compile simulation assertions.
module counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned STEP  = DefaultStep
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_max,
  output logic             o_hitTop,
  output logic [WIDTH-1:0] o_value
);

  // Initialised so the block works when o_hitTop is the only reset source.
  logic [WIDTH-1:0] value_q = '0;
  logic [WIDTH-1:0] value_d;

  counter_next #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_next (
    .value (value_q),
    .max   (i_max),
    .next  (value_d)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign o_value  = value_q;
  assign o_hitTop = (value_q >= i_max);

`ifdef COUNTER_ASSERT_EN
  if ((STEP < 1) || (64'(STEP) > ((64'd1 << WIDTH) - 64'd1))) begin : g_bad_step
    $error("counter: STEP %0d outside 1..2^WIDTH-1", STEP);
  end

  logic             past_valid_q = 1'b0;
  logic [WIDTH-1:0] max_q;

  always_ff @(posedge i_clk) begin
    past_valid_q <= 1'b1;
    max_q        <= i_max;
  end

  a_hit_top: assert property (@(posedge i_clk) o_hitTop == (o_value >= i_max));

  // A limit held across the edge means the count was clamped against it.
  a_in_range: assert property (@(posedge i_clk)
    (past_valid_q && (i_max == max_q)) |-> (o_value <= i_max));

  a_no_x: assert property (@(posedge i_clk) past_valid_q |-> !$isunknown(o_value));
`endif

endmodule

// File: tb/tb_counter.sv
module tb_counter;
  import counter_pkg::*;

  typedef struct {
    int         d;
    logic [3:0] v;
    logic       h;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  counter_if #(.WIDTH(4)) if1 ();
  counter_if #(.WIDTH(4)) if2 ();
  counter_if #(.WIDTH(4)) if3 ();

  // Step 1, driven reset.
  counter #(.WIDTH(4), .STEP(1)) dut1 (
    .i_clk    (clk),
    .i_reset  (if1.reset),
    .i_max    (if1.max),
    .o_hitTop (if1.hit_top),
    .o_value  (if1.value)
  );

  // Step 2, driven reset.
  counter #(.WIDTH(4), .STEP(2)) dut2 (
    .i_clk    (clk),
    .i_reset  (if2.reset),
    .i_max    (if2.max),
    .o_hitTop (if2.hit_top),
    .o_value  (if2.value)
  );

  // Step 1, o_hitTop fed back into i_reset; relies on power-up value.
  assign if3.reset = if3.hit_top;
  counter #(.WIDTH(4), .STEP(1)) dut3 (
    .i_clk    (clk),
    .i_reset  (if3.reset),
    .i_max    (if3.max),
    .o_hitTop (if3.hit_top),
    .o_value  (if3.value)
  );

  // Drive inputs for the current cycle and queue the outputs expected in it.
  task automatic chk(input int d, input logic rst, input logic [3:0] mx,
                     input logic [3:0] ev, input logic eh);
    case (d)
      1: begin if1.reset = rst; if1.max = mx; end
      2: begin if2.reset = rst; if2.max = mx; end
      default: if3.max = mx;
    endcase
    q.push_back('{d: d, v: ev, h: eh});
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the selected DUT mid-cycle.
  exp_t       mon_e;
  logic [3:0] mon_v;
  logic       mon_h;
  always @(negedge clk) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      case (mon_e.d)
        1: begin mon_v = if1.value; mon_h = if1.hit_top; end
        2: begin mon_v = if2.value; mon_h = if2.hit_top; end
        default: begin mon_v = if3.value; mon_h = if3.hit_top; end
      endcase
      checks += 2;
      if (mon_v !== mon_e.v) begin
        errors++;
        $display("FAIL value dut%0d @%0t: got %0d required %0d", mon_e.d, $time, mon_v, mon_e.v);
      end
      if (mon_h !== mon_e.h) begin
        errors++;
        $display("FAIL hit dut%0d @%0t: got %0b required %0b (value %0d)", mon_e.d, $time,
                 mon_h, mon_e.h, mon_v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int period;
    int wait_cnt;

    if1.reset = 1'b1; if1.max = 4'd5;
    if2.reset = 1'b1; if2.max = 4'd5;
    if3.max = 4'd0;
    @(posedge clk);
    #1;

    // STEP=1, max=5: reset state, then 0..5,0 with hit only at 5.
    chk(1, 1'b0, 4'd5, 4'd0, 1'b0);
    for (int v = 1; v <= 5; v++) chk(1, 1'b0, 4'd5, 4'(v), v == 5);
    chk(1, 1'b0, 4'd5, 4'd0, 1'b0);
    for (int v = 1; v <= 3; v++) chk(1, 1'b0, 4'd5, 4'(v), 1'b0);
    // Reset pulse while at 4: 0 at that edge, 1 on the next.
    chk(1, 1'b1, 4'd5, 4'd4, 1'b0);
    chk(1, 1'b0, 4'd5, 4'd0, 1'b0);
    // Limit dropped to 0 while at 1: hit at once, then stuck at 0 with hit.
    chk(1, 1'b0, 4'd0, 4'd1, 1'b1);
    for (int i = 0; i < 3; i++) chk(1, 1'b0, 4'd0, 4'd0, 1'b1);
    // Count to 7 under max=10, then lower the limit to 3.
    chk(1, 1'b0, 4'd10, 4'd0, 1'b0);
    for (int v = 1; v <= 6; v++) chk(1, 1'b0, 4'd10, 4'(v), 1'b0);
    chk(1, 1'b0, 4'd3, 4'd7, 1'b1);
    chk(1, 1'b0, 4'd3, 4'd0, 1'b0);
    chk(1, 1'b0, 4'd3, 4'd1, 1'b0);
    chk(1, 1'b0, 4'd3, 4'd2, 1'b0);
    chk(1, 1'b0, 4'd3, 4'd3, 1'b1);
    // Full range: max=15 counts 0..15 then 0.
    for (int v = 0; v <= 15; v++) chk(1, 1'b0, 4'd15, 4'(v), v == 15);
    chk(1, 1'b0, 4'd15, 4'd0, 1'b0);

    // STEP=2, max=5: 0,2,4,5,0; then max=15 clamps 14 -> 15.
    chk(2, 1'b0, 4'd5, 4'd0, 1'b0);
    chk(2, 1'b0, 4'd5, 4'd2, 1'b0);
    chk(2, 1'b0, 4'd5, 4'd4, 1'b0);
    chk(2, 1'b0, 4'd5, 4'd5, 1'b1);
    chk(2, 1'b0, 4'd5, 4'd0, 1'b0);
    for (int v = 2; v <= 14; v += 2) chk(2, 1'b0, 4'd15, 4'(v), 1'b0);
    chk(2, 1'b0, 4'd15, 4'd15, 1'b1);
    chk(2, 1'b0, 4'd15, 4'd0, 1'b0);

    // Feedback DUT: held at 0 by max=0 since power-up, then max=9.
    chk(3, 1'b0, 4'd0, 4'd0, 1'b1);
    chk(3, 1'b0, 4'd9, 4'd0, 1'b0);
    for (int r = 0; r < 2; r++) begin
      for (int v = 1; v <= 9; v++) chk(3, 1'b0, 4'd9, 4'(v), v == 9);
      chk(3, 1'b0, 4'd9, 4'd0, 1'b0);
    end

    // Feedback period measured between hit_top pulses.
    wait_cnt = 0;
    @(negedge clk);
    while (!if3.hit_top && wait_cnt < 40) begin
      @(negedge clk);
      wait_cnt++;
    end
    period = 0;
    do begin
      @(negedge clk);
      period++;
    end while (!if3.hit_top && period < 40);
    checks++;
    if (period != 10) begin
      errors++;
      $display("FAIL feedback_period: got %0d required 10", period);
    end
    checks++;
    if (period != int'(count_period(9, 1))) begin
      errors++;
      $display("FAIL period_function: measured %0d, count_period gives %0d", period,
               count_period(9, 1));
    end

    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
